// File: rtl/b11_stim_sequencer_if.sv
// ---------------------------------------------------------------------------
// b11_stim_sequencer_if
// Controller-side bundle for the b11 stimulus sequencer: program load,
// start/abort handshake and status/signature readback.
// Optional macro: B11_SEQ_LOOP_EN adds the loop_cnt field.
// ---------------------------------------------------------------------------
interface b11_stim_sequencer_if #(
  parameter int AW = 8
);
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [7:0]    load_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          abort;
`ifdef B11_SEQ_LOOP_EN
  logic [7:0]    loop_cnt;
`endif
  logic          busy;
  logic          done;
  logic [15:0]   sig;

`ifdef B11_SEQ_LOOP_EN
  // Test controller drives requests and reads back status
  modport master (
    output load_we, load_addr, load_data, prog_len, start, abort, loop_cnt,
    input  busy, done, sig
  );

  // Sequencer consumes requests and reports status
  modport slave (
    input  load_we, load_addr, load_data, prog_len, start, abort, loop_cnt,
    output busy, done, sig
  );
`else
  // Test controller drives requests and reads back status
  modport master (
    output load_we, load_addr, load_data, prog_len, start, abort,
    input  busy, done, sig
  );

  // Sequencer consumes requests and reports status
  modport slave (
    input  load_we, load_addr, load_data, prog_len, start, abort,
    output busy, done, sig
  );
`endif
endinterface : b11_stim_sequencer_if

// File: rtl/b11_stim_sequencer.sv
// ---------------------------------------------------------------------------
// b11_stim_sequencer
// Plays a loaded opcode program into the b11 core (x_in/stbi, one entry per
// clock) and compacts the observed x_out values into a 16-bit MISR.
//
// Pipeline per entry k (start accepted at edge E0):
//   E(k+1) program word read out of memory
//   E(k+2) entry driven on dut_x_in / dut_stbi
//   E(k+3) b11 registers the entry
//   E(k+4) x_out folded into the signature when the entry's obs bit is set
//
// Optional macro: B11_SEQ_LOOP_EN -- adds loop_cnt; the program is replayed
// loop_cnt+1 times back-to-back with a single done at the end.
// DEPTH must equal 2**AW.
// ---------------------------------------------------------------------------
module b11_stim_sequencer #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  b11_stim_sequencer_if.slave        ctl,
  output logic [5:0]                 dut_x_in,
  output logic                       dut_stbi,
  input  logic [5:0]                 dut_x_out
);

  localparam logic [15:0]   SIG_SEED  = 16'hFFFF;
  localparam logic [15:0]   MISR_POLY = 16'h002D;
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LEN_ONE   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,   // waiting for start; program may be loaded
    S_RUN,    // issuing program reads, one address per clock
    S_DRAIN,  // reads finished, waiting for the last fold
    S_DONE    // single-cycle completion pulse
  } state_e;

  // One MISR step: shift left, feed back the polynomial on the carry-out,
  // and mix in the observed core output.
  function automatic logic [15:0] misr_step(input logic [15:0] s,
                                            input logic [5:0]  x);
    return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ {10'b0, x};
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e        state_q,   state_d;
  logic [AW-1:0] addr_q,    addr_d;     // address being issued in RUN
  logic [AW-1:0] last_q,    last_d;     // address of the final entry
`ifdef B11_SEQ_LOOP_EN
  logic [7:0]    loop_q,    loop_d;     // passes still to play after this one
`endif
  logic          rd_vld_q,  rd_vld_d;   // rd_data_q holds a real entry
  logic          out_vld_q, out_vld_d;  // DUT inputs carry a real entry
  logic [5:0]    x_in_q,    x_in_d;
  logic          stbi_q,    stbi_d;
  logic          obs1_q,    obs1_d;     // obs of the entry on the DUT inputs
  logic          obs2_q,    obs2_d;     // obs of the entry b11 just registered
  logic [15:0]   sig_q,     sig_d;

  logic          mem_we;
  logic [7:0]    rd_data_q;
  logic [7:0]    mem [DEPTH];

  // -------------------------------------------------------------------------
  // Program memory: one write port, one registered read port
  // -------------------------------------------------------------------------
  // NOTE: the array and its read register deliberately have no reset; program
  // contents must survive reset, and rd_data_q is qualified by rd_vld_q.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[ctl.load_addr] <= ctl.load_data;
    end
    rd_data_q <= mem[addr_q];
  end

  // -------------------------------------------------------------------------
  // Next-state, datapath and MISR logic
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch; blocking '=' is correct here.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    last_d    = last_q;
`ifdef B11_SEQ_LOOP_EN
    loop_d    = loop_q;
`endif
    mem_we    = 1'b0;

    // The read/drive/observe pipeline advances every cycle; stages without
    // a valid entry present zeros to the core.
    rd_vld_d  = (state_q == S_RUN);
    out_vld_d = rd_vld_q;
    x_in_d    = rd_vld_q ? rd_data_q[5:0] : 6'd0;
    stbi_d    = rd_vld_q & rd_data_q[6];
    obs1_d    = rd_vld_q & rd_data_q[7];
    obs2_d    = obs1_q;
    sig_d     = obs2_q ? misr_step(sig_q, dut_x_out) : sig_q;

    unique case (state_q)
      S_IDLE: begin
        mem_we = ctl.load_we;
        if (ctl.start) begin
          sig_d = SIG_SEED;
          if (ctl.prog_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            addr_d  = '0;
            last_d  = AW'(ctl.prog_len - LEN_ONE);
`ifdef B11_SEQ_LOOP_EN
            loop_d  = ctl.loop_cnt;
`endif
          end
        end
      end

      S_RUN: begin
        if (addr_q == last_q) begin
`ifdef B11_SEQ_LOOP_EN
          // Wrapping straight to entry 0 keeps consecutive passes gapless.
          if (loop_q != 8'd0) begin
            loop_d = loop_q - 8'd1;
            addr_d = '0;
          end else begin
            state_d = S_DRAIN;
          end
`else
          state_d = S_DRAIN;
`endif
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end

      // Once the read and drive stages are empty, the final observed entry
      // sits in obs2_q and folds on the same edge that enters DONE.
      S_DRAIN: begin
        if (!rd_vld_q && !out_vld_q) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a same-cycle start: flush the
    // pipeline, silence the core inputs and freeze the signature.
    if (ctl.abort) begin
      state_d   = S_IDLE;
      rd_vld_d  = 1'b0;
      out_vld_d = 1'b0;
      x_in_d    = 6'd0;
      stbi_d    = 1'b0;
      obs1_d    = 1'b0;
      obs2_d    = 1'b0;
      sig_d     = sig_q;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // Control, pipeline and signature flops with asynchronous reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      last_q    <= '0;
`ifdef B11_SEQ_LOOP_EN
      loop_q    <= 8'd0;
`endif
      rd_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      x_in_q    <= 6'd0;
      stbi_q    <= 1'b0;
      obs1_q    <= 1'b0;
      obs2_q    <= 1'b0;
      sig_q     <= SIG_SEED;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      last_q    <= last_d;
`ifdef B11_SEQ_LOOP_EN
      loop_q    <= loop_d;
`endif
      rd_vld_q  <= rd_vld_d;
      out_vld_q <= out_vld_d;
      x_in_q    <= x_in_d;
      stbi_q    <= stbi_d;
      obs1_q    <= obs1_d;
      obs2_q    <= obs2_d;
      sig_q     <= sig_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded straight from flops so reset clears them at once
  // -------------------------------------------------------------------------
  assign ctl.busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign ctl.done = (state_q == S_DONE);
  assign ctl.sig  = sig_q;
  assign dut_x_in = x_in_q;
  assign dut_stbi = stbi_q;

endmodule : b11_stim_sequencer

// File: tb/tb_b11_stim_sequencer.sv
// ---------------------------------------------------------------------------
// tb_b11_stim_sequencer
// Self-checking bench for b11_stim_sequencer. A small stand-in for the b11
// core registers a fixed function of x_in/stbi onto x_out; the expected
// signature is computed from the program contents alone.
// Honours B11_SEQ_LOOP_EN when defined.
// ---------------------------------------------------------------------------
module tb_b11_stim_sequencer;

  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] dut_x_in;
  logic       dut_stbi;
  logic [5:0] dut_x_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  prog [DEPTH];
  logic [15:0] last_exp_sig = 16'hFFFF;

  b11_stim_sequencer_if #(.AW(AW)) ctl ();

  b11_stim_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock     (clock),
    .reset     (rst_n),
    .ctl       (ctl),
    .dut_x_in  (dut_x_in),
    .dut_stbi  (dut_stbi),
    .dut_x_out (dut_x_out)
  );

  always #5 clock = ~clock;

  // Stand-in core response: what x_out shows one clock after an entry.
  function automatic logic [5:0] core_resp(input logic [5:0] x, input logic s);
    return {x[4:0], x[5]} ^ (s ? 6'h2A : 6'h11);
  endfunction

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) dut_x_out <= 6'd0;
    else        dut_x_out <= core_resp(dut_x_in, dut_stbi);
  end

  function automatic logic [15:0] misr_fold(input logic [15:0] s, input logic [5:0] x);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h002D : 16'h0000) ^ {10'b0, x};
  endfunction

  // Expected signature: every observed entry of every pass, in play order.
  function automatic logic [15:0] model_sig(input int len, input int loops);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int p = 0; p <= loops; p++)
      for (int k = 0; k < len; k++)
        if (prog[k][7]) s = misr_fold(s, core_resp(prog[k][5:0], prog[k][6]));
    return s;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_entry(input int addr, input logic [7:0] data);
    ctl.load_we   = 1'b1;
    ctl.load_addr = addr[AW-1:0];
    ctl.load_data = data;
    tick();
    ctl.load_we   = 1'b0;
    prog[addr]    = data;
  endtask

  // Start a run and check busy/done/drive cycle by cycle, then the signature.
  task automatic run_prog(input string name, input int len, input int loops, input bit disturb);
    int          total;
    logic [15:0] exp_sig;
    logic [6:0]  exp_drv;
    logic        exp_busy, exp_done;
    logic [7:0]  e;
    total   = len * (loops + 1);
    exp_sig = model_sig(len, loops);
    ctl.prog_len = len[AW:0];
`ifdef B11_SEQ_LOOP_EN
    ctl.loop_cnt = loops[7:0];
`endif
    ctl.start = 1'b1;
    tick();
    ctl.start = 1'b0;
    for (int j = 0; j <= total + 4; j++) begin
      if (j > 0) tick();
      if (disturb && j == 2) begin
        ctl.start     = 1'b1;
        ctl.load_we   = 1'b1;
        ctl.load_addr = '0;
        ctl.load_data = ~prog[0];
      end
      if (disturb && j == 3) begin
        ctl.start   = 1'b0;
        ctl.load_we = 1'b0;
      end
      exp_done = (len == 0) ? (j == 0) : (j == total + 3);
      exp_busy = (len != 0) && (j <= total + 2);
      if (j >= 2 && j - 2 < total) begin
        e       = prog[(j - 2) % len];
        exp_drv = e[6:0];
      end else begin
        exp_drv = 7'd0;
      end
      n_checks++;
      if ({dut_stbi, dut_x_in} !== exp_drv)
        $display("FAIL %s drive E%0d: got %h want %h", name, j, {dut_stbi, dut_x_in}, exp_drv);
      else n_pass++;
      n_checks++;
      if (ctl.busy !== exp_busy)
        $display("FAIL %s busy E%0d: got %b want %b", name, j, ctl.busy, exp_busy);
      else n_pass++;
      n_checks++;
      if (ctl.done !== exp_done)
        $display("FAIL %s done E%0d: got %b want %b", name, j, ctl.done, exp_done);
      else n_pass++;
    end
    n_checks++;
    if (ctl.sig !== exp_sig)
      $display("FAIL %s sig: got %h want %h", name, ctl.sig, exp_sig);
    else n_pass++;
    last_exp_sig = exp_sig;
  endtask

  task automatic test_reset();
    ctl.load_we = 1'b0; ctl.load_addr = '0; ctl.load_data = '0;
    ctl.prog_len = '0;  ctl.start = 1'b0;   ctl.abort = 1'b0;
`ifdef B11_SEQ_LOOP_EN
    ctl.loop_cnt = '0;
`endif
    rst_n = 1'b0;
    #23;
    n_checks++;
    if ({ctl.busy, ctl.done, dut_stbi, dut_x_in, ctl.sig} !== {9'd0, 16'hFFFF})
      $display("FAIL reset values: got %b %b %h %h want 0 0 00 ffff",
               ctl.busy, ctl.done, {dut_stbi, dut_x_in}, ctl.sig);
    else n_pass++;
    rst_n = 1'b1;
    tick(); tick();
    n_checks++;
    if ({ctl.busy, ctl.done, dut_stbi, dut_x_in, ctl.sig} !== {9'd0, 16'hFFFF})
      $display("FAIL post-reset idle: got %b %b %h %h want 0 0 00 ffff",
               ctl.busy, ctl.done, {dut_stbi, dut_x_in}, ctl.sig);
    else n_pass++;
  endtask

  task automatic test_single_entry();
    load_entry(0, 8'hC5);
    run_prog("single", 1, 0, 1'b0);
    n_checks++;
    if (ctl.sig !== (16'hFFD3 ^ {10'b0, core_resp(6'd5, 1'b1)}))
      $display("FAIL single golden: got %h want %h", ctl.sig, 16'hFFD3 ^ {10'b0, core_resp(6'd5, 1'b1)});
    else n_pass++;
  endtask

  task automatic test_no_obs();
    for (int i = 0; i < 3; i++) load_entry(i, {1'b0, 7'($urandom)});
    run_prog("no_obs", 3, 0, 1'b0);
    n_checks++;
    if (ctl.sig !== 16'hFFFF) $display("FAIL no_obs sig: got %h want ffff", ctl.sig);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    run_prog("zero_len", 0, 0, 1'b0);
  endtask

  task automatic test_abort();
    logic [15:0] held;
    for (int i = 0; i < 10; i++) load_entry(i, 8'($urandom) | 8'h80);
    ctl.prog_len = 9'd10;
`ifdef B11_SEQ_LOOP_EN
    ctl.loop_cnt = 8'd0;
`endif
    ctl.start = 1'b1;
    tick();
    ctl.start = 1'b0;
    tick(); tick(); tick();
    ctl.abort = 1'b1;
    tick();
    ctl.abort = 1'b0;
    n_checks++;
    if ({ctl.busy, ctl.done, dut_stbi, dut_x_in, ctl.sig} !== {9'd0, 16'hFFFF})
      $display("FAIL abort state: got %b %b %h %h want 0 0 00 ffff",
               ctl.busy, ctl.done, {dut_stbi, dut_x_in}, ctl.sig);
    else n_pass++;
    for (int j = 0; j < 6; j++) begin
      tick();
      n_checks++;
      if ({ctl.busy, ctl.done, dut_stbi, dut_x_in} !== 9'd0)
        $display("FAIL abort quiet %0d: got %b %b %h want 0 0 00", j, ctl.busy, ctl.done, {dut_stbi, dut_x_in});
      else n_pass++;
    end
    run_prog("after_abort", 10, 0, 1'b0);
    // Abort together with start: nothing starts and the signature holds.
    held = last_exp_sig;
    ctl.prog_len = 9'd5;
    ctl.start = 1'b1;
    ctl.abort = 1'b1;
    tick();
    ctl.start = 1'b0;
    ctl.abort = 1'b0;
    n_checks++;
    if ({ctl.busy, ctl.done, ctl.sig} !== {2'b00, held})
      $display("FAIL start+abort: got %b %b %h want 0 0 %h", ctl.busy, ctl.done, ctl.sig, held);
    else n_pass++;
  endtask

  task automatic test_ignored_requests();
    for (int i = 0; i < 6; i++) load_entry(i, 8'($urandom));
    prog[0] = prog[0] | 8'h80;
    load_entry(0, prog[0]);
    run_prog("disturbed", 6, 0, 1'b1);
    run_prog("rerun", 6, 0, 1'b0);
  endtask

  task automatic test_random();
    int len, loops;
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 40);
      loops = 0;
`ifdef B11_SEQ_LOOP_EN
      loops = $urandom_range(0, 3);
`endif
      for (int i = 0; i < len; i++) load_entry(i, 8'($urandom));
      run_prog($sformatf("random%0d", r), len, loops, 1'b0);
    end
  endtask

  task automatic test_full_depth();
    for (int i = 0; i < DEPTH; i++) load_entry(i, 8'($urandom));
    run_prog("full_depth", DEPTH, 0, 1'b0);
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 12; i++) load_entry(i, 8'($urandom) | 8'h80);
    ctl.prog_len = 9'd12;
`ifdef B11_SEQ_LOOP_EN
    ctl.loop_cnt = 8'd0;
`endif
    ctl.start = 1'b1;
    tick();
    ctl.start = 1'b0;
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ctl.busy, ctl.done, dut_stbi, dut_x_in, ctl.sig} !== {9'd0, 16'hFFFF})
      $display("FAIL midrun reset: got %b %b %h %h want 0 0 00 ffff",
               ctl.busy, ctl.done, {dut_stbi, dut_x_in}, ctl.sig);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    run_prog("after_reset", 12, 0, 1'b0);
  endtask

`ifdef B11_SEQ_LOOP_EN
  task automatic test_loop();
    for (int i = 0; i < 4; i++) load_entry(i, 8'($urandom) | 8'h40);
    run_prog("loop3x4", 4, 2, 1'b0);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_entry();
    test_no_obs();
    test_zero_len();
    test_abort();
    test_ignored_requests();
    test_random();
    test_full_depth();
    test_reset_midrun();
`ifdef B11_SEQ_LOOP_EN
    test_loop();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_b11_stim_sequencer
